sysbus_arbiter: RTL and testbench
=================================

// Module: sysbus_arbiter
// PURPOSE
//  Shares the single system bus between the instruction cache (client 0, "ic") and data cache
//  (client 1, "dc"). Grants one client a whole transaction: request handshake plus full response
//  burst. Round-robin priority alternates between clients. Sits between both caches and the top bus port.
// PARAMETERS
//  BUS_TAG_WIDTH   13  width of reqtag/resptag
//  BUS_DATA_WIDTH  64  width of req/resp
//  MAX_BEATS       8   max response beats per transaction (64B line / 8B); counter width $clog2(MAX_BEATS)+1
// PORTS
//  clk          in   1    clock
//  reset        in   1    asynchronous, active-high reset
//  ic_reqcyc    in   1    ic request valid; held with ic_req/ic_reqtag until ic_reqack
//  ic_req       in   BDW  ic request address/data
//  ic_reqtag    in   BTW  ic request tag
//  ic_reqack    out  1    1-cycle ack of ic request
//  ic_respcyc   out  1    response beat valid to ic
//  ic_resp      out  BDW  response data to ic
//  ic_resptag   out  BTW  response tag to ic
//  ic_respack   in   1    ic accepts response beats
//  dc_*         --   --   identical set for dc (client 1)
//  bus_reqcyc   out  1    to bus: request valid
//  bus_req      out  BDW  to bus: request address/data
//  bus_reqtag   out  BTW  to bus: request tag
//  bus_reqack   in   1    from bus: request accepted
//  bus_respcyc  in   1    from bus: response beat valid
//  bus_resp     in   BDW  from bus: response data
//  bus_resptag  in   BTW  from bus: response tag
//  bus_respack  out  1    to bus: response ack (forwarded from granted client)
//  busy         out  1    state != IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE, grant=0, prio=ic, beat_cnt=0; every output 0.
//  - States: IDLE -> REQ -> RESP -> IDLE. grant, prio and beat_cnt are registered.
//  - IDLE: if any *_reqcyc, pick winner (both -> prio client, one -> that client), latch grant,
//    go REQ. Client reqcyc at edge N -> bus_reqcyc=1 from cycle N+1 (1-cycle arbitration latency).
//  - REQ: bus_reqcyc/req/reqtag = granted client's inputs (comb mux on registered grant).
//    bus_reqack passed combinationally to granted client's reqack only; other reqack stays 0.
//    On bus_reqack=1: go RESP. Granted client dropping reqcyc before ack is illegal (assert).
//  - RESP: bus_reqcyc=0. bus_respcyc/resp/resptag routed to granted client; ungranted client
//    sees respcyc=0, resp=0, resptag=0. bus_respack = granted client's respack.
//    beat_cnt increments on each cycle with bus_respcyc=1, saturates at MAX_BEATS.
//    Exit when bus_respcyc=0 and beat_cnt!=0 (burst ended): go IDLE, prio=other client,
//    beat_cnt=0. bus_respcyc=0 before first beat: stay in RESP (wait for burst start).
//  - beat_cnt reaching MAX_BEATS with bus_respcyc still 1: protocol error, assertion fires;
//    arbiter keeps routing beats until respcyc drops.
//  - bus_respcyc=1 while IDLE or REQ: dropped (no client sees it); assertion fires.
//  - Request arriving while busy: held off (no ack) until after return to IDLE; a pending
//    requester is granted in the IDLE cycle immediately following RESP exit (no starvation:
//    prio flip guarantees the waiting client wins next).
//  - Same-cycle bus_reqack and bus_respcyc in REQ: ack taken, beat counted, go RESP.
//  - Reset mid-transaction: outputs drop to 0 immediately; in-flight burst discarded.
// STRUCTURE
//  - sysbus_pkg: arb_state_t enum {ARB_IDLE, ARB_REQ, ARB_RESP}; client_id_t (IC=0, DC=1);
//    SYSBUS_READ/WRITE/MEMORY tag constants shared with the caches.
//  - Sub-module rr_pick2: 2-request round-robin picker (req[1:0], prio -> gnt_id, gnt_valid), comb.
// TESTING
//  - ic only: ic_reqcyc=1 req=0x1000 at cycle 0 -> bus_reqcyc=1 req=0x1000 at cycle 1; reqack
//    cycle 3 -> ic_reqack=1 cycle 3; 8 beats to ic only; IDLE on respcyc drop; prio=dc.
//  - Simultaneous ic+dc after reset -> ic granted first, dc granted in IDLE cycle after ic burst
//    ends; third simultaneous pair -> ic again (strict alternation).
//  - dc burst of 8 beats with ic_reqcyc asserted mid-burst -> ic_reqack stays 0, ic_respcyc 0
//    throughout; ic granted immediately after.
//  - bus_reqack and first bus_respcyc same cycle -> beat_cnt=1, state RESP, beat routed to client.
//  - reset pulse during beat 4 of dc burst -> all outputs 0 same cycle; after release ic request
//    granted with prio=ic, beat_cnt starts at 0.
//  - Stray bus_respcyc in IDLE -> no client respcyc, error assertion flagged; 9th beat -> assertion.

Source files
------------

// File: rtl/sysbus_pkg.sv
// ---------------------------------------------------------------------------
// sysbus_pkg
//   Types and constants shared by the system-bus arbiter and the caches.
//   - arb_state_t : arbiter transaction state
//   - client_id_t : bus client index (IC = instruction cache, DC = data cache)
//   - SYSBUS_*    : request tag constants used by the caches
//   - other_client: returns the client that is not the argument
// ---------------------------------------------------------------------------
package sysbus_pkg;

    localparam int SYSBUS_TAG_WIDTH  = 13;
    localparam int SYSBUS_DATA_WIDTH = 64;
    localparam int SYSBUS_MAX_BEATS  = 8;

    // Bit 12 distinguishes reads from writes; bit 11 selects memory space.
    localparam logic [SYSBUS_TAG_WIDTH-1:0] SYSBUS_WRITE  = 13'h0000;
    localparam logic [SYSBUS_TAG_WIDTH-1:0] SYSBUS_READ   = 13'h1000;
    localparam logic [SYSBUS_TAG_WIDTH-1:0] SYSBUS_MEMORY = 13'h0800;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        CLIENT_IC = 1'b0,
        CLIENT_DC = 1'b1
    } client_id_t;

    function automatic client_id_t other_client(input client_id_t c);
        return (c == CLIENT_IC) ? CLIENT_DC : CLIENT_IC;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
//   Two-requester round-robin picker, purely combinational.
//   req[1:0]  in   request vector (bit 0 = IC, bit 1 = DC)
//   prio      in   client that wins when both request
//   gnt_id    out  selected client
//   gnt_valid out  at least one request present
// ---------------------------------------------------------------------------
module rr_pick2
    import sysbus_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_id,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = prio;
        case (req)
            2'b01:   gnt_id = CLIENT_IC;
            2'b10:   gnt_id = CLIENT_DC;
            default: gnt_id = prio;
        endcase
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// ---------------------------------------------------------------------------
// sysbus_arbiter
//   Shares the system bus between the instruction cache (client 0, ic) and
//   the data cache (client 1, dc). A grant covers a whole transaction: the
//   request handshake plus the complete response burst. Priority alternates
//   after every transaction.
//
//   State   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no owner; arbitrate among pending requests
//   REQ     | granted client's request driven to bus, waiting bus_reqack
//   RESP    | routing response beats to granted client until burst ends
//
// Ports
//   clk, reset                   clock, async active-high reset
//   ic_reqcyc/req/reqtag         ic request (held until ic_reqack)
//   ic_reqack                    1-cycle ack of ic request
//   ic_respcyc/resp/resptag      response beats to ic
//   ic_respack                   ic accepts response beats
//   dc_*                         same set for dc
//   bus_reqcyc/req/reqtag        request to bus
//   bus_reqack                   bus accepted request
//   bus_respcyc/resp/resptag     response beats from bus
//   bus_respack                  granted client's respack toward bus
//   busy                         state != IDLE
// ---------------------------------------------------------------------------
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int BUS_TAG_WIDTH  = SYSBUS_TAG_WIDTH,
    parameter int BUS_DATA_WIDTH = SYSBUS_DATA_WIDTH,
    parameter int MAX_BEATS      = SYSBUS_MAX_BEATS,
    parameter bit CHECK_PROTOCOL = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      ic_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] ic_req,
    input  logic [BUS_TAG_WIDTH-1:0]  ic_reqtag,
    output logic                      ic_reqack,
    output logic                      ic_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] ic_resp,
    output logic [BUS_TAG_WIDTH-1:0]  ic_resptag,
    input  logic                      ic_respack,

    input  logic                      dc_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] dc_req,
    input  logic [BUS_TAG_WIDTH-1:0]  dc_reqtag,
    output logic                      dc_reqack,
    output logic                      dc_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] dc_resp,
    output logic [BUS_TAG_WIDTH-1:0]  dc_resptag,
    input  logic                      dc_respack,

    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,

    output logic                      busy
);

    localparam int CNT_W = $clog2(MAX_BEATS) + 1;
    localparam logic [CNT_W-1:0] BEAT_MAX = CNT_W'(MAX_BEATS);

    arb_state_t       state;
    client_id_t       grant;
    client_id_t       prio;
    logic [CNT_W-1:0] beat_cnt;

    logic pick_id;
    logic pick_valid;

    rr_pick2 u_pick (
        .req       ({dc_reqcyc, ic_reqcyc}),
        .prio      (prio),
        .gnt_id    (pick_id),
        .gnt_valid (pick_valid)
    );

    // Granted client's request/ack inputs, muxed on the registered grant.
    logic                      sel_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] sel_req;
    logic [BUS_TAG_WIDTH-1:0]  sel_reqtag;
    logic                      sel_respack;

    always_comb begin
        if (grant == CLIENT_DC) begin
            sel_reqcyc  = dc_reqcyc;
            sel_req     = dc_req;
            sel_reqtag  = dc_reqtag;
            sel_respack = dc_respack;
        end else begin
            sel_reqcyc  = ic_reqcyc;
            sel_req     = ic_req;
            sel_reqtag  = ic_reqtag;
            sel_respack = ic_respack;
        end
    end

    logic in_req;
    logic in_resp;
    logic ack_now;
    logic route_resp;
    logic beat;
    logic gnt_ic;
    logic gnt_dc;

    assign in_req  = (state == ARB_REQ);
    assign in_resp = (state == ARB_RESP);
    assign ack_now = in_req && bus_reqack;
    // A beat arriving together with the request ack already belongs to
    // the granted transaction, so the routing window opens in that cycle.
    assign route_resp = in_resp || ack_now;
    assign beat       = route_resp && bus_respcyc;
    assign gnt_ic     = (grant == CLIENT_IC);
    assign gnt_dc     = (grant == CLIENT_DC);

    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        ic_reqack   = 1'b0;
        dc_reqack   = 1'b0;
        ic_respcyc  = 1'b0;
        ic_resp     = '0;
        ic_resptag  = '0;
        dc_respcyc  = 1'b0;
        dc_resp     = '0;
        dc_resptag  = '0;

        if (in_req) begin
            bus_reqcyc = sel_reqcyc;
            bus_req    = sel_req;
            bus_reqtag = sel_reqtag;
            ic_reqack  = bus_reqack && gnt_ic;
            dc_reqack  = bus_reqack && gnt_dc;
        end

        if (route_resp) begin
            bus_respack = sel_respack;
            if (gnt_ic) begin
                ic_respcyc = bus_respcyc;
                ic_resp    = bus_resp;
                ic_resptag = bus_resptag;
            end else begin
                dc_respcyc = bus_respcyc;
                dc_resp    = bus_resp;
                dc_resptag = bus_resptag;
            end
        end
    end

    assign busy = (state != ARB_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_IDLE;
            grant    <= CLIENT_IC;
            prio     <= CLIENT_IC;
            beat_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant <= client_id_t'(pick_id);
                        state <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    if (bus_reqack) begin
                        state <= ARB_RESP;
                        if (bus_respcyc) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                ARB_RESP: begin
                    if (bus_respcyc) begin
                        if (beat_cnt != BEAT_MAX) begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end else if (beat_cnt != '0) begin
                        // Burst ended: hand priority to the other client so
                        // a requester held off during this burst wins next.
                        state    <= ARB_IDLE;
                        prio     <= other_client(grant);
                        beat_cnt <= '0;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Protocol violation flags (combinational, evaluated each cycle).
    logic err_stray_resp;
    logic err_overrun;
    logic err_req_drop;

    assign err_stray_resp = bus_respcyc && !route_resp;
    assign err_overrun    = beat && (beat_cnt == BEAT_MAX);
    assign err_req_drop   = in_req && !sel_reqcyc;

    always_ff @(posedge clk) begin
        if (CHECK_PROTOCOL && !reset) begin
            assert (!err_stray_resp);
            assert (!err_overrun);
            assert (!err_req_drop);
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
module tb_sysbus_arbiter;
    import sysbus_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        ic_reqcyc = 1'b0;
    logic [63:0] ic_req = '0;
    logic [12:0] ic_reqtag = '0;
    logic        ic_reqack;
    logic        ic_respcyc;
    logic [63:0] ic_resp;
    logic [12:0] ic_resptag;
    logic        ic_respack = 1'b0;

    logic        dc_reqcyc = 1'b0;
    logic [63:0] dc_req = '0;
    logic [12:0] dc_reqtag = '0;
    logic        dc_reqack;
    logic        dc_respcyc;
    logic [63:0] dc_resp;
    logic [12:0] dc_resptag;
    logic        dc_respack = 1'b0;

    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack = 1'b0;
    logic        bus_respcyc = 1'b0;
    logic [63:0] bus_resp = '0;
    logic [12:0] bus_resptag = '0;
    logic        bus_respack;
    logic        busy;

    int n_cmp = 0;
    int n_mis = 0;

    sysbus_arbiter #(
        .BUS_TAG_WIDTH  (13),
        .BUS_DATA_WIDTH (64),
        .MAX_BEATS      (8),
        .CHECK_PROTOCOL (1'b0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ic_reqcyc   (ic_reqcyc),
        .ic_req      (ic_req),
        .ic_reqtag   (ic_reqtag),
        .ic_reqack   (ic_reqack),
        .ic_respcyc  (ic_respcyc),
        .ic_resp     (ic_resp),
        .ic_resptag  (ic_resptag),
        .ic_respack  (ic_respack),
        .dc_reqcyc   (dc_reqcyc),
        .dc_req      (dc_req),
        .dc_reqtag   (dc_reqtag),
        .dc_reqack   (dc_reqack),
        .dc_respcyc  (dc_respcyc),
        .dc_resp     (dc_resp),
        .dc_resptag  (dc_resptag),
        .dc_respack  (dc_respack),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bus_reqcyc"}, bus_reqcyc, 0);
        chk({tag, "_bus_req"}, bus_req, 0);
        chk({tag, "_bus_respack"}, bus_respack, 0);
        chk({tag, "_ic_reqack"}, ic_reqack, 0);
        chk({tag, "_dc_reqack"}, dc_reqack, 0);
        chk({tag, "_ic_respcyc"}, ic_respcyc, 0);
        chk({tag, "_dc_respcyc"}, dc_respcyc, 0);
        chk({tag, "_ic_resp"}, ic_resp, 0);
        chk({tag, "_dc_resp"}, dc_resp, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_state"}, dut.state, ARB_IDLE);
        chk({tag, "_beat_cnt"}, dut.beat_cnt, 0);
    endtask

    // Called while the arbiter is in IDLE with the winner's request applied.
    task automatic handshake(input logic is_dc, input logic [63:0] exp_req, input logic [12:0] exp_tag);
        @(negedge clk); #1;
        chk("hs_state_req", dut.state, ARB_REQ);
        chk("hs_bus_reqcyc", bus_reqcyc, 1);
        chk("hs_bus_req", bus_req, exp_req);
        chk("hs_bus_reqtag", bus_reqtag, exp_tag);
        chk("hs_ic_reqack_pre", ic_reqack, 0);
        chk("hs_dc_reqack_pre", dc_reqack, 0);
        chk("hs_busy", busy, 1);
        @(negedge clk);
        bus_reqack = 1'b1;
        #1;
        chk("hs_ic_reqack", ic_reqack, !is_dc);
        chk("hs_dc_reqack", dc_reqack, is_dc);
        @(negedge clk);
        bus_reqack = 1'b0;
        if (is_dc) dc_reqcyc = 1'b0; else ic_reqcyc = 1'b0;
        #1;
        chk("hs_state_resp", dut.state, ARB_RESP);
        chk("hs_bus_reqcyc_off", bus_reqcyc, 0);
    endtask

    task automatic burst(input int n, input logic is_dc, input logic [63:0] base,
                         input int raise_ic_at, input bit do_end);
        int exp_cnt;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus_respcyc = 1'b1;
            bus_resp    = base + 64'(i);
            bus_resptag = SYSBUS_READ | 13'(i);
            ic_respack  = !is_dc;
            dc_respack  = is_dc;
            if (i == raise_ic_at) begin
                ic_reqcyc = 1'b1;
                ic_req    = 64'h6000;
                ic_reqtag = SYSBUS_READ | 13'h6;
            end
            #1;
            exp_cnt = (i > 8) ? 8 : i;
            chk("bt_beat_cnt", dut.beat_cnt, exp_cnt);
            chk("bt_overrun", dut.err_overrun, (i >= 8));
            chk("bt_ic_respcyc", ic_respcyc, !is_dc);
            chk("bt_dc_respcyc", dc_respcyc, is_dc);
            chk("bt_ic_resp", ic_resp, is_dc ? 64'h0 : base + 64'(i));
            chk("bt_dc_resp", dc_resp, is_dc ? base + 64'(i) : 64'h0);
            chk("bt_resptag", is_dc ? dc_resptag : ic_resptag, SYSBUS_READ | 13'(i));
            chk("bt_bus_respack", bus_respack, 1);
            chk("bt_ic_reqack", ic_reqack, 0);
            chk("bt_dc_reqack", dc_reqack, 0);
        end
        if (do_end) begin
            @(negedge clk);
            bus_respcyc = 1'b0;
            bus_resp    = '0;
            bus_resptag = '0;
            ic_respack  = 1'b0;
            dc_respack  = 1'b0;
            #1;
            chk("be_state", dut.state, ARB_RESP);
            chk("be_beat_cnt", dut.beat_cnt, (n > 8) ? 8 : n);
            chk("be_respcyc", ic_respcyc | dc_respcyc, 0);
        end
    endtask

    task automatic back_to_idle(input logic exp_prio);
        @(negedge clk); #1;
        chk("idle_state", dut.state, ARB_IDLE);
        chk("idle_prio", dut.prio, exp_prio);
        chk("idle_beat_cnt", dut.beat_cnt, 0);
        chk("idle_bus_reqcyc", bus_reqcyc, 0);
    endtask

    initial begin
        // Reset state
        #2;
        chk_all_zero("rst");
        chk("rst_prio", dut.prio, CLIENT_IC);
        chk("rst_grant", dut.grant, CLIENT_IC);

        // ic alone: 1-cycle arbitration latency, 8 beats, prio flips to dc
        @(negedge clk);
        reset     = 1'b0;
        ic_reqcyc = 1'b1;
        ic_req    = 64'h1000;
        ic_reqtag = SYSBUS_READ | 13'h1;
        #1;
        chk("t1_no_req_yet", bus_reqcyc, 0);
        handshake(1'b0, 64'h1000, SYSBUS_READ | 13'h1);
        burst(8, 1'b0, 64'hA0, -1, 1'b1);
        back_to_idle(CLIENT_DC);
        chk("t1_busy", busy, 0);

        // reset pulse restores prio to ic
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_all_zero("rst2");
        chk("rst2_prio", dut.prio, CLIENT_IC);
        @(negedge clk);
        reset = 1'b0;

        // simultaneous ic+dc: ic first, dc right after
        @(negedge clk);
        ic_reqcyc = 1'b1; ic_req = 64'h2000; ic_reqtag = SYSBUS_READ | 13'h2;
        dc_reqcyc = 1'b1; dc_req = 64'h3000; dc_reqtag = SYSBUS_MEMORY | 13'h3;
        #1;
        chk("t2_idle", dut.state, ARB_IDLE);
        handshake(1'b0, 64'h2000, SYSBUS_READ | 13'h2);
        burst(2, 1'b0, 64'hB0, -1, 1'b1);
        back_to_idle(CLIENT_DC);
        handshake(1'b1, 64'h3000, SYSBUS_MEMORY | 13'h3);
        burst(1, 1'b1, 64'hC0, -1, 1'b1);
        back_to_idle(CLIENT_IC);

        // third simultaneous pair: ic again; reqack and first beat together
        @(negedge clk);
        ic_reqcyc = 1'b1; ic_req = 64'h4000; ic_reqtag = SYSBUS_READ | 13'h4;
        dc_reqcyc = 1'b1; dc_req = 64'h5000; dc_reqtag = SYSBUS_MEMORY | 13'h5;
        @(negedge clk); #1;
        chk("t3_state_req", dut.state, ARB_REQ);
        chk("t3_bus_req", bus_req, 64'h4000);
        @(negedge clk);
        bus_reqack  = 1'b1;
        bus_respcyc = 1'b1;
        bus_resp    = 64'hBEEF;
        ic_respack  = 1'b1;
        #1;
        chk("t3_ic_reqack", ic_reqack, 1);
        chk("t3_ic_respcyc", ic_respcyc, 1);
        chk("t3_ic_resp", ic_resp, 64'hBEEF);
        chk("t3_dc_respcyc", dc_respcyc, 0);
        chk("t3_bus_respack", bus_respack, 1);
        @(negedge clk);
        bus_reqack  = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        ic_respack  = 1'b0;
        ic_reqcyc   = 1'b0;
        #1;
        chk("t3_state_resp", dut.state, ARB_RESP);
        chk("t3_beat_cnt", dut.beat_cnt, 1);
        back_to_idle(CLIENT_DC);

        // dc burst with ic requesting mid-burst: ic held off, then granted
        handshake(1'b1, 64'h5000, SYSBUS_MEMORY | 13'h5);
        burst(8, 1'b1, 64'hD0, 3, 1'b1);
        back_to_idle(CLIENT_IC);
        handshake(1'b0, 64'h6000, SYSBUS_READ | 13'h6);
        burst(2, 1'b0, 64'hE0, -1, 1'b1);
        back_to_idle(CLIENT_DC);

        // reset during beat 4 of a dc burst
        @(negedge clk);
        dc_reqcyc = 1'b1; dc_req = 64'h7000; dc_reqtag = SYSBUS_MEMORY | 13'h7;
        handshake(1'b1, 64'h7000, SYSBUS_MEMORY | 13'h7);
        burst(3, 1'b1, 64'hF0, -1, 1'b0);
        @(negedge clk);
        bus_respcyc = 1'b1;
        bus_resp    = 64'hF3;
        dc_respack  = 1'b1;
        reset       = 1'b1;
        #1;
        chk_all_zero("t4_rst");
        @(negedge clk);
        reset       = 1'b0;
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        dc_respack  = 1'b0;
        ic_reqcyc   = 1'b1; ic_req = 64'h8000; ic_reqtag = SYSBUS_READ | 13'h8;
        #1;
        chk("t4_prio", dut.prio, CLIENT_IC);
        chk("t4_beat_cnt", dut.beat_cnt, 0);
        handshake(1'b0, 64'h8000, SYSBUS_READ | 13'h8);
        burst(1, 1'b0, 64'h100, -1, 1'b1);
        back_to_idle(CLIENT_DC);

        // stray beat in IDLE is dropped and flagged
        @(negedge clk);
        bus_respcyc = 1'b1;
        bus_resp    = 64'hDEAD;
        ic_respack  = 1'b1;
        #1;
        chk("t5_ic_respcyc", ic_respcyc, 0);
        chk("t5_dc_respcyc", dc_respcyc, 0);
        chk("t5_ic_resp", ic_resp, 0);
        chk("t5_dc_resp", dc_resp, 0);
        chk("t5_bus_respack", bus_respack, 0);
        chk("t5_stray_flag", dut.err_stray_resp, 1);
        @(negedge clk);
        bus_respcyc = 1'b0;
        bus_resp    = '0;
        ic_respack  = 1'b0;
        dc_reqcyc   = 1'b1; dc_req = 64'h9000; dc_reqtag = SYSBUS_MEMORY | 13'h9;
        #1;
        chk("t5_stray_clear", dut.err_stray_resp, 0);
        chk("t5_state", dut.state, ARB_IDLE);

        // 9-beat burst: ninth beat still routed, overrun flagged
        handshake(1'b1, 64'h9000, SYSBUS_MEMORY | 13'h9);
        burst(9, 1'b1, 64'h200, -1, 1'b1);
        back_to_idle(CLIENT_IC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
